spi_bus_bridge: RTL and testbench

- Converts the byte stream from the existing SPI target (`spi_target`) into Xosera host-bus cycles for `xosera_main`.
- Successor to the fixed 2-byte command/payload SPI scheme:
  - one command byte may be followed by any number of payload bytes (burst), each producing one bus cycle;
  - byte-select auto-toggles, so 16-bit words stream naturally;
  - reads are prefetched so SPI read data is ready before it is shifted out.
- Sits between `spi_target` and `xosera_main` in the board top.

---
 rtl/spi_bus_bridge_pkg.sv | 25 ++
 rtl/spi_bus_bridge_if.sv | 39 +++
 rtl/spi_bus_bridge.sv | 166 ++++++++++++++++
 tb/tb_spi_bus_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_bridge_pkg
// Description : Command-byte fields, bus polarities and bridge state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package spi_bus_bridge_pkg;

  localparam int SPI_CMD_CS = 7;
  localparam int SPI_CMD_WR = 6;
  localparam int SPI_CMD_RS = 5;
  localparam int SPI_CMD_BS = 4;

  localparam logic CS_ENABLED = 1'b0;
  localparam logic RnW_READ   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    CYCLE  = 2'd2,
    IGNORE = 2'd3
  } spi_bridge_st_t;

endpackage
`default_nettype wire

// File: rtl/spi_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_bridge_if
// Description : SPI-target byte stream and Xosera host-bus signals of the bridge
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_bus_bridge_if;

  logic       spi_select_i;
  logic       spi_rx_strobe_i;
  logic [7:0] spi_rx_byte_i;
  logic       spi_tx_strobe_i;
  logic [7:0] spi_tx_byte_o;
  logic       bus_cs_n_o;
  logic       bus_rd_nwr_o;
  logic       bus_bytesel_o;
  logic [3:0] bus_reg_num_o;
  logic [7:0] bus_data_o;
  logic [7:0] bus_data_i;
  logic       soft_reset_o;
  logic       overrun_o;
  logic       busy_o;

  // Bridge side
  modport slave (
    input  spi_select_i, spi_rx_strobe_i, spi_rx_byte_i, spi_tx_strobe_i, bus_data_i,
    output spi_tx_byte_o, bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o,
           bus_data_o, soft_reset_o, overrun_o, busy_o
  );

  // Surrounding board logic (spi_target + xosera_main)
  modport master (
    output spi_select_i, spi_rx_strobe_i, spi_rx_byte_i, spi_tx_strobe_i, bus_data_i,
    input  spi_tx_byte_o, bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o,
           bus_data_o, soft_reset_o, overrun_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/spi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_bridge
// Description : Turns SPI command/payload byte bursts into Xosera bus cycles
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bus_bridge
  import spi_bus_bridge_pkg::*;
#(
  parameter int          CS_HOLD     = 2,
  parameter int          READ_LAT    = 2,
  parameter bit          WORD_TOGGLE = 1'b1,
  parameter logic [7:0]  IDLE_BYTE   = 8'hCB
) (
  input  wire logic         clk,
  input  wire logic         reset_n_i,
  spi_bus_bridge_if.slave   bus
);

  localparam logic [3:0] c_HOLD_LAST = 4'(CS_HOLD);
  localparam logic [3:0] c_READ_AT   = 4'(READ_LAT);

  spi_bridge_st_t r_state;
  spi_bridge_st_t w_state_next;
  logic [3:0]     r_hold_cnt;
  logic           r_desel;

  logic w_rx;
  logic w_tx;
  logic w_write_mode;
  logic w_trigger;
  logic w_hold_done;
  logic w_start;

  // A strobe coinciding with deselect is treated as if it never arrived
  assign w_rx         = bus.spi_rx_strobe_i & bus.spi_select_i;
  assign w_tx         = bus.spi_tx_strobe_i & bus.spi_select_i;
  assign w_write_mode = (bus.bus_rd_nwr_o != RnW_READ);
  assign w_trigger    = w_write_mode ? w_rx : w_tx;
  assign w_hold_done  = (r_hold_cnt == c_HOLD_LAST);
  assign w_start      = (r_state != CYCLE) && (w_state_next == CYCLE);

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_rx) begin
          if (bus.spi_rx_byte_i[SPI_CMD_RS] || !bus.spi_rx_byte_i[SPI_CMD_CS]) begin
            w_state_next = IGNORE;
          end else if (bus.spi_rx_byte_i[SPI_CMD_WR]) begin
            w_state_next = WAIT;
          end else begin
            w_state_next = CYCLE;
          end
        end
      end
      WAIT: begin
        if (!bus.spi_select_i) begin
          w_state_next = IDLE;
        end else if (w_trigger) begin
          w_state_next = CYCLE;
        end
      end
      CYCLE: begin
        // CS is never cut short; a deselect is only honoured at the end
        if (w_hold_done) begin
          w_state_next = (r_desel || !bus.spi_select_i) ? IDLE : WAIT;
        end
      end
      IGNORE: begin
        if (!bus.spi_select_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_cs_n_o = ~CS_ENABLED;
    bus.busy_o     = 1'b0;
    if (r_state == CYCLE) begin
      bus.bus_cs_n_o = CS_ENABLED;
      bus.busy_o     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      bus.bus_rd_nwr_o  <= RnW_READ;
      bus.bus_bytesel_o <= 1'b0;
      bus.bus_reg_num_o <= 4'd0;
      bus.bus_data_o    <= 8'd0;
      bus.spi_tx_byte_o <= IDLE_BYTE;
      bus.soft_reset_o  <= 1'b0;
      bus.overrun_o     <= 1'b0;
      r_hold_cnt        <= 4'd0;
      r_desel           <= 1'b0;
    end else begin
      bus.soft_reset_o <= 1'b0;

      if (w_start) begin
        r_hold_cnt <= 4'd1;
        r_desel    <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_rx) begin
            bus.bus_rd_nwr_o  <= bus.spi_rx_byte_i[SPI_CMD_WR] ? ~RnW_READ : RnW_READ;
            bus.bus_bytesel_o <= bus.spi_rx_byte_i[SPI_CMD_BS];
            bus.bus_reg_num_o <= bus.spi_rx_byte_i[3:0];
            if (bus.spi_rx_byte_i[SPI_CMD_RS]) begin
              bus.soft_reset_o <= 1'b1;
              bus.overrun_o    <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (!bus.spi_select_i) begin
            bus.spi_tx_byte_o <= IDLE_BYTE;
          end else if (w_trigger && w_write_mode) begin
            bus.bus_data_o <= bus.spi_rx_byte_i;
          end
        end
        CYCLE: begin
          r_hold_cnt <= r_hold_cnt + 4'd1;
          if (!bus.spi_select_i) begin
            r_desel <= 1'b1;
          end
          if (w_trigger) begin
            bus.overrun_o <= 1'b1;
          end
          if (!w_write_mode && (r_hold_cnt == c_READ_AT)) begin
            bus.spi_tx_byte_o <= bus.bus_data_i;
          end
          if (w_hold_done) begin
            if (WORD_TOGGLE) begin
              bus.bus_bytesel_o <= ~bus.bus_bytesel_o;
            end
            // Placed after the capture so a deselect always wins
            if (r_desel || !bus.spi_select_i) begin
              bus.spi_tx_byte_o <= IDLE_BYTE;
            end
          end
        end
        IGNORE: begin
          if (!bus.spi_select_i) begin
            bus.spi_tx_byte_o <= IDLE_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_bus_bridge
// Description : Directed bench; instance a uses defaults, b is CS_HOLD=8 / no toggle
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bus_bridge;

  logic       clk;
  logic       r_rst_n;
  logic       r_sel;
  logic       r_rx_stb;
  logic [7:0] r_rx_byte;
  logic       r_tx_stb;
  logic [7:0] r_bus_din;
  int         n_total;
  int         n_bad;

  spi_bus_bridge_if ifa ();
  spi_bus_bridge_if ifb ();

  assign ifa.spi_select_i    = r_sel;
  assign ifa.spi_rx_strobe_i = r_rx_stb;
  assign ifa.spi_rx_byte_i   = r_rx_byte;
  assign ifa.spi_tx_strobe_i = r_tx_stb;
  assign ifa.bus_data_i      = r_bus_din;
  assign ifb.spi_select_i    = r_sel;
  assign ifb.spi_rx_strobe_i = r_rx_stb;
  assign ifb.spi_rx_byte_i   = r_rx_byte;
  assign ifb.spi_tx_strobe_i = r_tx_stb;
  assign ifb.bus_data_i      = r_bus_din;

  spi_bus_bridge u_dut_a (
    .clk       (clk),
    .reset_n_i (r_rst_n),
    .bus       (ifa.slave)
  );

  spi_bus_bridge #(
    .CS_HOLD     (8),
    .READ_LAT    (2),
    .WORD_TOGGLE (1'b0),
    .IDLE_BYTE   (8'hCB)
  ) u_dut_b (
    .clk       (clk),
    .reset_n_i (r_rst_n),
    .bus       (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    r_rx_byte = b;
    r_rx_stb  = 1'b1;
    step();
    r_rx_stb  = 1'b0;
  endtask

  task automatic send_tx();
    r_tx_stb = 1'b1;
    step();
    r_tx_stb = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_cs"},    32'(ifa.bus_cs_n_o),    32'd1);
    chk({tag, "_rdnwr"}, 32'(ifa.bus_rd_nwr_o),  32'd1);
    chk({tag, "_bsel"},  32'(ifa.bus_bytesel_o), 32'd0);
    chk({tag, "_reg"},   32'(ifa.bus_reg_num_o), 32'd0);
    chk({tag, "_dout"},  32'(ifa.bus_data_o),    32'd0);
    chk({tag, "_tx"},    32'(ifa.spi_tx_byte_o), 32'hCB);
    chk({tag, "_soft"},  32'(ifa.soft_reset_o),  32'd0);
    chk({tag, "_ovr"},   32'(ifa.overrun_o),     32'd0);
    chk({tag, "_busy"},  32'(ifa.busy_o),        32'd0);
  endtask

  initial begin
    logic [7:0] burst [4];
    n_total   = 0;
    n_bad     = 0;
    r_rst_n   = 1'b0;
    r_sel     = 1'b0;
    r_rx_stb  = 1'b0;
    r_rx_byte = 8'h00;
    r_tx_stb  = 1'b0;
    r_bus_din = 8'h00;
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;

    step(); step();
    check_reset_a("rst");
    r_rst_n = 1'b1;
    step();

    // Write burst C3 / 12 / 34; b sees the second byte during its long cycle
    r_sel = 1'b1;
    step();
    send_rx(8'hC3);
    chk("wr_cmd_cs",    32'(ifa.bus_cs_n_o),    32'd1);
    chk("wr_cmd_reg",   32'(ifa.bus_reg_num_o), 32'd3);
    chk("wr_cmd_rdnwr", 32'(ifa.bus_rd_nwr_o),  32'd0);
    send_rx(8'h12);
    chk("wr1_cs_c1",  32'(ifa.bus_cs_n_o),    32'd0);
    chk("wr1_busy",   32'(ifa.busy_o),        32'd1);
    chk("wr1_data",   32'(ifa.bus_data_o),    32'h12);
    chk("wr1_bsel",   32'(ifa.bus_bytesel_o), 32'd0);
    step();
    chk("wr1_cs_c2",  32'(ifa.bus_cs_n_o),    32'd0);
    step();
    chk("wr1_cs_end", 32'(ifa.bus_cs_n_o),    32'd1);
    chk("wr1_tog",    32'(ifa.bus_bytesel_o), 32'd1);
    send_rx(8'h34);
    chk("wr2_cs_c1",  32'(ifa.bus_cs_n_o),    32'd0);
    chk("wr2_data",   32'(ifa.bus_data_o),    32'h34);
    chk("wr2_bsel",   32'(ifa.bus_bytesel_o), 32'd1);
    step();
    chk("wr2_cs_c2",  32'(ifa.bus_cs_n_o),    32'd0);
    step();
    chk("wr2_cs_end", 32'(ifa.bus_cs_n_o),    32'd1);
    chk("wr2_tog",    32'(ifa.bus_bytesel_o), 32'd0);
    chk("wr_ovr_a",   32'(ifa.overrun_o),     32'd0);
    chk("ovr_b_set",  32'(ifb.overrun_o),     32'd1);
    chk("ovr_b_drop", 32'(ifb.bus_data_o),    32'h12);
    r_sel = 1'b0;
    repeat (10) step();
    chk("desel_a_tx", 32'(ifa.spi_tx_byte_o), 32'hCB);
    chk("desel_b_cs", 32'(ifb.bus_cs_n_o),    32'd1);
    chk("ovr_b_stky", 32'(ifb.overrun_o),     32'd1);

    // Soft reset command clears overrun, then payload is ignored
    r_sel = 1'b1;
    step();
    send_rx(8'h20);
    chk("rs_soft_a",  32'(ifa.soft_reset_o),  32'd1);
    chk("rs_soft_b",  32'(ifb.soft_reset_o),  32'd1);
    chk("rs_ovr_clr", 32'(ifb.overrun_o),     32'd0);
    chk("rs_cs",      32'(ifa.bus_cs_n_o),    32'd1);
    chk("rs_reg",     32'(ifa.bus_reg_num_o), 32'd0);
    step();
    chk("rs_soft_1c", 32'(ifa.soft_reset_o),  32'd0);
    send_rx(8'hC3);
    chk("ign_cs1",    32'(ifa.bus_cs_n_o),    32'd1);
    send_rx(8'h55);
    chk("ign_cs2",    32'(ifa.bus_cs_n_o),    32'd1);
    step();
    chk("ign_cs3",    32'(ifa.bus_cs_n_o),    32'd1);
    chk("ign_data",   32'(ifa.bus_data_o),    32'h34);
    r_sel = 1'b0;
    step(); step();

    // Read prefetch cmd 85, then a tx strobe reads the odd byte
    r_bus_din = 8'hA5;
    r_sel = 1'b1;
    step();
    send_rx(8'h85);
    chk("rd_cs_c1",  32'(ifa.bus_cs_n_o),    32'd0);
    chk("rd_rdnwr",  32'(ifa.bus_rd_nwr_o),  32'd1);
    chk("rd_reg",    32'(ifa.bus_reg_num_o), 32'd5);
    chk("rd_tx_c1",  32'(ifa.spi_tx_byte_o), 32'hCB);
    step();
    chk("rd_cs_c2",  32'(ifa.bus_cs_n_o),    32'd0);
    step();
    chk("rd_cs_end", 32'(ifa.bus_cs_n_o),    32'd1);
    chk("rd_tx_c3",  32'(ifa.spi_tx_byte_o), 32'hA5);
    chk("rd_bsel",   32'(ifa.bus_bytesel_o), 32'd1);
    r_bus_din = 8'h5A;
    send_tx();
    chk("rd2_cs",    32'(ifa.bus_cs_n_o),    32'd0);
    chk("rd2_bsel",  32'(ifa.bus_bytesel_o), 32'd1);
    step(); step();
    chk("rd2_tx",    32'(ifa.spi_tx_byte_o), 32'h5A);
    chk("rd2_tog",   32'(ifa.bus_bytesel_o), 32'd0);
    chk("rd_b_ovr",  32'(ifb.overrun_o),     32'd1);
    chk("rd_b_tx",   32'(ifb.spi_tx_byte_o), 32'hA5);

    // Deselect on the first CS-low cycle of a prefetch
    send_tx();
    chk("dsm_cs_c1", 32'(ifa.bus_cs_n_o),    32'd0);
    r_sel = 1'b0;
    step();
    chk("dsm_cs_c2", 32'(ifa.bus_cs_n_o),    32'd0);
    step();
    chk("dsm_cs_end", 32'(ifa.bus_cs_n_o),   32'd1);
    chk("dsm_busy",  32'(ifa.busy_o),        32'd0);
    chk("dsm_tx",    32'(ifa.spi_tx_byte_o), 32'hCB);
    chk("dsm_b_tx",  32'(ifb.spi_tx_byte_o), 32'hCB);
    step();
    chk("dsm_idle",  32'(ifa.bus_cs_n_o),    32'd1);
    repeat (10) step();

    // Four-byte write burst: b never toggles byte-select
    r_sel = 1'b1;
    step();
    send_rx(8'hC1);
    for (int i = 0; i < 4; i++) begin
      send_rx(burst[i]);
      chk($sformatf("nt_b_cs%0d", i),   32'(ifb.bus_cs_n_o),    32'd0);
      chk($sformatf("nt_b_bsel%0d", i), 32'(ifb.bus_bytesel_o), 32'd0);
      repeat (9) step();
    end
    chk("nt_b_data", 32'(ifb.bus_data_o),    32'h44);
    chk("nt_a_bsel", 32'(ifa.bus_bytesel_o), 32'd0);
    chk("nt_a_reg",  32'(ifa.bus_reg_num_o), 32'd1);

    // Reset while CS is low
    send_rx(8'h77);
    chk("rmc_cs_lo", 32'(ifa.bus_cs_n_o),    32'd0);
    r_rst_n = 1'b0;
    step();
    check_reset_a("rmc");
    chk("rmc_b_cs",  32'(ifb.bus_cs_n_o),    32'd1);
    r_rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
